uart_tx_arbiter: RTL and testbench

- Shares one 8-bit even-parity serial byte transmitter between NUM_REQ requesters, and sequences its load/start strobes.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte marked last has been sent.
- Sits between readout/slow-control sources and the serializer in the DIF link path.
- A watchdog aborts a packet if the serializer stops handshaking.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the DIF serial-byte transmitter arbiter: FSM encoding and header tag.
package uart_tx_pkg;

    localparam int DATA_BIT_NUM_DEF = 8;
    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    // Header byte announcing which requester owns the following packet.
    function automatic logic [7:0] hdr_byte(input logic [3:0] g);
        return {HDR_TAG, g};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin pick: first valid index at or after ptr_i, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one serial byte transmitter between NUM_REQ requesters with packet-locked round-robin.
// Define TX_ID_HEADER_EN to prefix each packet with an owner-ID header byte.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BIT_NUM = DATA_BIT_NUM_DEF,
    parameter int TIMEOUT_CYC  = 1048576,
    parameter int TO_W         = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_BIT_NUM-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic [DATA_BIT_NUM-1:0]         ser_data,
    output logic                            ser_load,
    output logic                            ser_start,
    input  logic                            ser_idle,
    output logic                            busy,
    output logic                            err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT_CYC - 1);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic                    last_q, last_d;
    logic [TO_W-1:0]         wd_q, wd_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic                    load_q, load_d;
    logic                    start_q, start_d;
    logic [DATA_BIT_NUM-1:0] data_q, data_d;
    logic                    busy_q;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic [IDX_W-1:0]        nxt_ptr;
    logic                    abort, pkt_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .valid_i (req_valid),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign nxt_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        last_d  = last_q;
        wd_d    = '0;
        ready_d = '0;
        load_d  = 1'b0;
        start_d = 1'b0;
        data_d  = data_q;
        abort   = 1'b0;
        pkt_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
`ifdef TX_ID_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
`ifdef TX_ID_HEADER_EN
            ST_HDR: begin
                if (ser_idle) begin
                    load_d  = 1'b1;
                    start_d = 1'b1;
                    data_d  = DATA_BIT_NUM'(hdr_byte(4'(gidx_q)));
                    last_d  = 1'b0;
                    state_d = ST_WAIT_BUSY;
                end
            end
`endif
            ST_LOAD: begin
                // A stalled owner keeps the grant; the watchdog only guards the serializer.
                if (req_valid[gidx_q] && ser_idle) begin
                    ready_d = grant_q;
                    load_d  = 1'b1;
                    start_d = 1'b1;
                    data_d  = req_data[gidx_q*DATA_BIT_NUM +: DATA_BIT_NUM];
                    last_d  = req_last[gidx_q];
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!ser_idle)          state_d = ST_WAIT_DONE;
                else if (wd_q == WD_MAX) abort  = 1'b1;
                else                    wd_d    = wd_q + TO_W'(1);
            end
            ST_WAIT_DONE: begin
                if (ser_idle) begin
                    if (last_q) pkt_end = 1'b1;
                    else        state_d = ST_LOAD;
                end else if (wd_q == WD_MAX) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort || pkt_end) begin
            grant_d = '0;
            rr_d    = nxt_ptr;
            state_d = ST_IDLE;
        end
        err_d = abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
            wd_q    <= '0;
            ready_q <= '0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            ready_q <= ready_d;
            load_q  <= load_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= (state_d != ST_IDLE);
            err_q   <= err_d;
        end
    end

    assign req_ready   = ready_q;
    assign grant       = grant_q;
    assign ser_data    = data_q;
    assign ser_load    = load_q;
    assign ser_start   = start_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, 16 clk/baud serializer model, watchdog instance.
module tb_uart_tx_arbiter;

`ifdef TX_ID_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FRAME = 176;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         gap;
    } rq_t;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic [3:0] r;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic [7:0]  ser_data;
    logic        ser_load, ser_start, ser_idle, busy, err_timeout;

    logic [3:0]  t_req_valid, t_req_last, t_req_ready, t_grant;
    logic [31:0] t_req_data;
    logic [7:0]  t_ser_data;
    logic        t_ser_load, t_ser_start, t_ser_idle, t_busy, t_err;

    int   compared = 0;
    int   failed = 0;
    int   cyc = 0;
    int   n_starts = 0;
    int   rdy_cnt[4];
    int   start_cyc[$];
    sb_t  sb[$];
    rq_t  rq[4][$];
    bit   loaded[4];
    int   gapcnt[4];

    logic       s_active = 1'b0;
    int         s_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BIT_NUM(8), .TIMEOUT_CYC(1024), .TO_W(11)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .ser_data(ser_data), .ser_load(ser_load),
        .ser_start(ser_start), .ser_idle(ser_idle), .busy(busy), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BIT_NUM(8), .TIMEOUT_CYC(64), .TO_W(7)) dut_to (
        .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_data(t_req_data), .req_last(t_req_last),
        .req_ready(t_req_ready), .grant(t_grant), .ser_data(t_ser_data), .ser_load(t_ser_load),
        .ser_start(t_ser_start), .ser_idle(t_ser_idle), .busy(t_busy), .err_timeout(t_err)
    );

    // Serializer: 11-bit frame at 16 clk/baud, idle reasserted in the last 3 clk of the stop bit.
    always @(posedge clk) begin
        if (ser_start) begin
            s_active <= 1'b1;
            s_cnt    <= 0;
        end else if (s_active) begin
            if (s_cnt == FRAME - 1) s_active <= 1'b0;
            else                    s_cnt    <= s_cnt + 1;
        end
    end
    assign ser_idle = !s_active || (s_cnt >= FRAME - 3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input int r, input logic [7:0] d, input logic last, input int gap, input logic first);
        rq_t it;
        sb_t e;
        it.d = d; it.last = last; it.gap = gap;
        rq[r].push_back(it);
        if (first && HDR != 0) begin
            e.g = 4'(1 << r); e.d = 8'hA0 | 8'(r); e.r = 4'h0;
            sb.push_back(e);
        end
        e.g = 4'(1 << r); e.d = d; e.r = 4'(1 << r);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        chk(nm, 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    task automatic wait_starts(input string nm, input int n);
        for (int k = 0; k < 4000; k++) begin
            if (n_starts >= n) break;
            @(negedge clk);
        end
        chk(nm, 32'(n_starts >= n), 32'd1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_grant"}, 32'(grant), 32'd0);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({pfx, "_ser_load"}, 32'(ser_load), 32'd0);
        chk({pfx, "_ser_start"}, 32'(ser_start), 32'd0);
        chk({pfx, "_ser_data"}, 32'(ser_data), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    // Requester models: present queue head (after optional gap), pop on req_ready.
    initial begin
        req_valid = '0; req_last = '0; req_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    loaded[i] = 1'b0;
                end
                if (!loaded[i] && rq[i].size() > 0) begin
                    loaded[i] = 1'b1;
                    gapcnt[i] = rq[i][0].gap;
                end
                if (loaded[i] && gapcnt[i] > 0) gapcnt[i]--;
                if (loaded[i]) begin
                    req_valid[i]        = (gapcnt[i] == 0);
                    req_data[i*8 +: 8]  = rq[i][0].d;
                    req_last[i]         = rq[i][0].last;
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*8 +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor: every transmit strobe is matched against the next expected byte.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ser_start) begin
                    n_starts++;
                    start_cyc.push_back(cyc);
                    chk("expected_byte_available", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("ser_data", 32'(ser_data), 32'(e.d));
                        chk("grant_at_start", 32'(grant), 32'(e.g));
                        chk("req_ready_at_start", 32'(req_ready), 32'(e.r));
                        chk("ser_load", 32'(ser_load), 32'd1);
                    end
                end else if (req_ready != 4'h0) begin
                    chk("stray_req_ready", 32'(req_ready), 32'd0);
                end
                if (err_timeout) chk("main_err_timeout", 32'(err_timeout), 32'd0);
                for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
            end
        end
    end

    initial begin
        int n0, s, e_cyc;
        logic got;
        rst = 1'b1;
        t_req_valid = '0; t_req_last = '0; t_req_data = '0; t_ser_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin rdy_cnt[i] = 0; loaded[i] = 1'b0; gapcnt[i] = 0; end
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Requester 1: three-byte packet, one frame per byte
        start_cyc.delete();
        issue(1, 8'h12, 1'b0, 0, 1'b1);
        issue(1, 8'h34, 1'b0, 0, 1'b0);
        issue(1, 8'h56, 1'b1, 0, 1'b0);
        wait_done("pkt1_done");
        chk("pkt1_n_starts", 32'(start_cyc.size()), 32'(3 + HDR));
        if (start_cyc.size() >= 3) begin
            chk("pkt1_spacing_a", 32'(start_cyc[start_cyc.size()-2] - start_cyc[start_cyc.size()-3]), 32'(FRAME));
            chk("pkt1_spacing_b", 32'(start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2]), 32'(FRAME));
        end
        chk("pkt1_ready_count", 32'(rdy_cnt[1]), 32'd3);
        chk("pkt1_grant_after", 32'(grant), 32'd0);
        chk("pkt1_busy_after", 32'(busy), 32'd0);

        // Reset in WAIT_DONE drops requester 2's packet; the remainder is never sent
        issue(2, 8'h99, 1'b0, 0, 1'b1);
        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
        chk("rst_first_byte_sent", 32'(sb.size()), 32'd0);
        repeat (20) @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        rq[2].delete(); loaded[2] = 1'b0; req_valid[2] = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;

        // rr_ptr=0 after reset: 0 then 2
        issue(0, 8'h0A, 1'b1, 0, 1'b1);
        issue(2, 8'h2B, 1'b1, 0, 1'b1);
        wait_done("rr1_done");
        // requester 0 alone leaves rr_ptr=1, then 2 wins over 0
        issue(0, 8'h0C, 1'b1, 0, 1'b1);
        wait_done("rr2_done");
        issue(2, 8'h2D, 1'b1, 0, 1'b1);
        issue(0, 8'h0D, 1'b1, 0, 1'b1);
        wait_done("rr3_done");

        // Requester 3 stalls 500 clk mid-packet; requester 0 must wait
        n0 = n_starts;
        issue(3, 8'h31, 1'b0, 0, 1'b1);
        issue(3, 8'h32, 1'b1, 500, 1'b0);
        issue(0, 8'h0E, 1'b1, 0, 1'b1);
        wait_starts("hold_first_byte", n0 + 1 + HDR);
        repeat (300) @(negedge clk);
        chk("hold_grant", 32'(grant), 32'h8);
        chk("hold_busy", 32'(busy), 32'd1);
        wait_done("hold_done");
        chk("ready_count_req0", 32'(rdy_cnt[0]), 32'd4);
        chk("ready_count_req3", 32'(rdy_cnt[3]), 32'd2);

        // Watchdog: serializer never drops idle, TIMEOUT_CYC=64
        t_req_valid = 4'b0010; t_req_last = 4'b0010; t_req_data = 32'h0000_5A00;
        got = 1'b0; s = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (t_ser_start) begin got = 1'b1; s = cyc; end
        end
        chk("to_start_seen", 32'(got), 32'd1);
        t_req_valid = 4'b0000;
        got = 1'b0; e_cyc = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (t_err) begin got = 1'b1; e_cyc = cyc; end
        end
        chk("to_err_seen", 32'(got), 32'd1);
        chk("to_latency", 32'(e_cyc - s), 32'd64);
        chk("to_grant_cleared", 32'(t_grant), 32'd0);
        @(negedge clk);
        chk("to_err_one_cycle", 32'(t_err), 32'd0);
        chk("to_busy_idle", 32'(t_busy), 32'd0);
        t_req_valid = 4'b0110;
        @(negedge clk);
        chk("to_rr_advanced", 32'(t_grant), 32'h4);
        t_req_valid = 4'b0000;

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
